// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - multi-lane register rename with speculative/committed maps and a circular free list
// Defining RMT_PERF_CNT_EN adds the saturating rename_stall_cnt output.
module rename_map_table #(
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6,
  parameter int RENAME_WIDTH           = 2,
  parameter int COMMIT_WIDTH           = 2
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [RENAME_WIDTH-1:0]                          rename_valid,
  input  logic [RENAME_WIDTH-1:0]                          rename_regwrite,
  input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rename_rs1,
  input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rename_rs2,
  input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       rename_rd,
  output logic                                             rename_ready,
  output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_rs1,
  output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_rs2,
  output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_rd,
  output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_rd_old,
  input  logic [COMMIT_WIDTH-1:0]                          commit_valid,
  input  logic [COMMIT_WIDTH-1:0]                          commit_with_write,
  input  logic [COMMIT_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       commit_arch_rd,
  input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   commit_new_phy,
  input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   commit_old_phy,
  input  logic                                             flush,
  output logic [PHYSICAL_REG_NUM_WIDTH:0]                  free_count
`ifdef RMT_PERF_CNT_EN
  ,
  output logic [31:0]                                      rename_stall_cnt
`endif
);
  localparam int A  = ARCH_REG_NUM_WIDTH;
  localparam int P  = PHYSICAL_REG_NUM_WIDTH;
  localparam int RW = RENAME_WIDTH;
  localparam int CW = COMMIT_WIDTH;
  localparam int NA = 1 << A;
  localparam int NP = 1 << P;
  localparam int F  = NP - NA;
  localparam logic [P:0] F_CNT  = F[P:0];
  localparam logic [P:0] RW_CNT = RW[P:0];

  logic [P-1:0]  spec_map  [NA];
  logic [P-1:0]  cmap      [NA];
  logic [P-1:0]  cmap_next [NA];
  logic [P-1:0]  free_list [NP];
  logic [P-1:0]  spec_head, arch_head, tail;
  logic [P-1:0]  arch_head_next, tail_next;
  logic [P-1:0]  alloc_cnt, free_cnt;
  logic [RW-1:0] lane_alloc;
  logic [P-1:0]  new_phy   [RW];
  logic [CW-1:0] push_en;
  logic [P-1:0]  push_idx  [CW];
  logic          accept;

  assign rename_ready = (free_count >= RW_CNT) & ~flush;
  assign accept       = rename_ready & (|rename_valid);

  // Older allocating lanes override the map lookup; the youngest matching lane wins.
  always_comb begin : rename_path
    logic [A-1:0] s1, s2, d;
    alloc_cnt  = '0;
    lane_alloc = '0;
    phy_rs1    = '0;
    phy_rs2    = '0;
    phy_rd     = '0;
    phy_rd_old = '0;
    for (int k = 0; k < RW; k++) begin
      s1 = rename_rs1[k*A +: A];
      s2 = rename_rs2[k*A +: A];
      d  = rename_rd[k*A +: A];
      lane_alloc[k] = rename_valid[k] & rename_regwrite[k] & (d != '0);
      new_phy[k]    = lane_alloc[k] ? free_list[spec_head + alloc_cnt] : '0;
      phy_rs1[k*P +: P]    = spec_map[s1];
      phy_rs2[k*P +: P]    = spec_map[s2];
      phy_rd_old[k*P +: P] = spec_map[d];
      for (int j = 0; j < k; j++) begin
        if (lane_alloc[j] && rename_rd[j*A +: A] == s1) phy_rs1[k*P +: P] = new_phy[j];
        if (lane_alloc[j] && rename_rd[j*A +: A] == s2) phy_rs2[k*P +: P] = new_phy[j];
        if (lane_alloc[j] && rename_rd[j*A +: A] == d)  phy_rd_old[k*P +: P] = new_phy[j];
      end
      phy_rd[k*P +: P] = new_phy[k];
      if (lane_alloc[k]) alloc_cnt = alloc_cnt + P'(1);
    end
  end

  always_comb begin : commit_path
    logic [A-1:0] crd;
    cmap_next      = cmap;
    tail_next      = tail;
    arch_head_next = arch_head;
    free_cnt       = '0;
    push_en        = '0;
    for (int l = 0; l < CW; l++) begin
      crd         = commit_arch_rd[l*A +: A];
      push_idx[l] = tail_next;
      if (commit_valid[l] && commit_with_write[l] && crd != '0) begin
        push_en[l]     = 1'b1;
        cmap_next[crd] = commit_new_phy[l*P +: P];
        tail_next      = tail_next + P'(1);
        arch_head_next = arch_head_next + P'(1);
        free_cnt       = free_cnt + P'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NA; i++) begin
        spec_map[i] <= P'(i);
        cmap[i]     <= P'(i);
      end
      for (int i = 0; i < NP; i++) free_list[i] <= (i < F) ? P'(NA + i) : '0;
      spec_head  <= '0;
      arch_head  <= '0;
      tail       <= P'(F);
      free_count <= F_CNT;
    end else begin
      cmap      <= cmap_next;
      arch_head <= arch_head_next;
      tail      <= tail_next;
      for (int l = 0; l < CW; l++)
        if (push_en[l]) free_list[push_idx[l]] <= commit_old_phy[l*P +: P];
      // Flush rewinds to the committed state including this cycle's commits.
      if (flush) begin
        spec_map   <= cmap_next;
        spec_head  <= arch_head_next;
        free_count <= {1'b0, tail_next - arch_head_next};
      end else begin
        if (accept) begin
          for (int k = 0; k < RW; k++)
            if (lane_alloc[k]) spec_map[rename_rd[k*A +: A]] <= new_phy[k];
          spec_head <= spec_head + alloc_cnt;
        end
        free_count <= free_count - (accept ? {1'b0, alloc_cnt} : '0) + {1'b0, free_cnt};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && free_cnt != '0) assert (free_count != F_CNT);
  end

`ifdef RMT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) rename_stall_cnt <= '0;
    else if ((|rename_valid) && !rename_ready && rename_stall_cnt != '1)
      rename_stall_cnt <= rename_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_rename_map_table.sv
// tb/tb_rename_map_table.sv - directed and randomized checks of rename_map_table against a queue-based model
module tb_rename_map_table;
  localparam int A = 5, P = 6, RW = 2, CW = 2, NA = 32;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] rename_valid, rename_regwrite;
  logic [RW*A-1:0] rename_rs1, rename_rs2, rename_rd;
  logic rename_ready;
  logic [RW*P-1:0] phy_rs1, phy_rs2, phy_rd, phy_rd_old;
  logic [CW-1:0] commit_valid, commit_with_write;
  logic [CW*A-1:0] commit_arch_rd;
  logic [CW*P-1:0] commit_new_phy, commit_old_phy;
  logic flush;
  logic [P:0] free_count;
`ifdef RMT_PERF_CNT_EN
  logic [31:0] rename_stall_cnt;
`endif

  int errors = 0, checks = 0;
  int smap[NA];
  int cmap[NA];
  int fq[$];
  typedef struct {int rd; int newp; int oldp;} rob_t;
  rob_t rob[$];

  rename_map_table #(.ARCH_REG_NUM_WIDTH(A), .PHYSICAL_REG_NUM_WIDTH(P),
                     .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .rename_valid(rename_valid), .rename_regwrite(rename_regwrite),
    .rename_rs1(rename_rs1), .rename_rs2(rename_rs2), .rename_rd(rename_rd),
    .rename_ready(rename_ready),
    .phy_rs1(phy_rs1), .phy_rs2(phy_rs2), .phy_rd(phy_rd), .phy_rd_old(phy_rd_old),
    .commit_valid(commit_valid), .commit_with_write(commit_with_write),
    .commit_arch_rd(commit_arch_rd), .commit_new_phy(commit_new_phy),
    .commit_old_phy(commit_old_phy), .flush(flush), .free_count(free_count)
`ifdef RMT_PERF_CNT_EN
    , .rename_stall_cnt(rename_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rename_valid = '0; rename_regwrite = '0;
    rename_rs1 = '0; rename_rs2 = '0; rename_rd = '0;
    commit_valid = '0; commit_with_write = '0;
    commit_arch_rd = '0; commit_new_phy = '0; commit_old_phy = '0;
    flush = 1'b0;
  endtask

  task automatic set_lane(input int k, input bit v, input bit w, input int r1, input int r2, input int d);
    rename_valid[k] = v;
    rename_regwrite[k] = w;
    rename_rs1[k*A +: A] = A'(r1);
    rename_rs2[k*A +: A] = A'(r2);
    rename_rd[k*A +: A] = A'(d);
  endtask

  // Commits are always the oldest write-renames still in flight.
  task automatic set_commits(input int n);
    for (int l = 0; l < CW; l++) begin
      if (l < n && l < rob.size()) begin
        commit_valid[l] = 1'b1;
        commit_with_write[l] = 1'b1;
        commit_arch_rd[l*A +: A] = A'(rob[l].rd);
        commit_new_phy[l*P +: P] = P'(rob[l].newp);
        commit_old_phy[l*P +: P] = P'(rob[l].oldp);
      end
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NA; i++) begin smap[i] = i; cmap[i] = i; end
    fq.delete();
    for (int i = 32; i < 64; i++) fq.push_back(i);
    rob.delete();
  endtask

  // Check outputs for the current inputs, then clock once and advance the model.
  task automatic step();
    int tmap[NA];
    int cnt, e1, e2, eo, er, a1, a2, ad, p;
    bit al, acc, exp_ready, dup;
    #1;
    exp_ready = (fq.size() >= RW) && !flush;
    chk("ready", rename_ready, exp_ready);
    chk("free_count", free_count, fq.size());
    tmap = smap;
    cnt = 0;
    for (int k = 0; k < RW; k++) begin
      a1 = rename_rs1[k*A +: A];
      a2 = rename_rs2[k*A +: A];
      ad = rename_rd[k*A +: A];
      e1 = tmap[a1]; e2 = tmap[a2]; eo = tmap[ad];
      al = rename_valid[k] && rename_regwrite[k] && ad != 0;
      er = 0;
      if (al) begin
        er = (cnt < fq.size()) ? fq[cnt] : -1;
        tmap[ad] = er;
        cnt++;
      end
      if (e1 >= 0) chk("phy_rs1", phy_rs1[k*P +: P], e1);
      if (e2 >= 0) chk("phy_rs2", phy_rs2[k*P +: P], e2);
      if (eo >= 0) chk("phy_rd_old", phy_rd_old[k*P +: P], eo);
      if (er >= 0 && (al || ad == 0)) chk("phy_rd", phy_rd[k*P +: P], er);
      if (al && er >= 0 && exp_ready) begin
        dup = 1'b0;
        for (int i = 1; i < NA; i++) if (smap[i] == er) dup = 1'b1;
        chk("no_dup_alloc", phy_rd[k*P +: P] == P'(er) && dup, 0);
      end
    end
    acc = exp_ready && (|rename_valid);
    @(posedge clk);
    for (int l = 0; l < CW; l++) begin
      if (commit_valid[l] && commit_with_write[l] && commit_arch_rd[l*A +: A] != 0) begin
        cmap[commit_arch_rd[l*A +: A]] = commit_new_phy[l*P +: P];
        fq.push_back(commit_old_phy[l*P +: P]);
        void'(rob.pop_front());
      end
    end
    if (flush) begin
      smap = cmap;
      for (int i = rob.size() - 1; i >= 0; i--) fq.push_front(rob[i].newp);
      rob.delete();
    end else if (acc) begin
      for (int k = 0; k < RW; k++) begin
        ad = rename_rd[k*A +: A];
        if (rename_valid[k] && rename_regwrite[k] && ad != 0) begin
          p = fq.pop_front();
          rob.push_back('{ad, p, smap[ad]});
          smap[ad] = p;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset state and intra-group forwarding
    do_reset();
    set_lane(0, 1, 1, 7, 0, 3);
    set_lane(1, 1, 1, 3, 31, 3);
    #1;
    chk("t1_ready", rename_ready, 1);
    chk("t1_fc", free_count, 32);
    chk("t1_rs1_0", phy_rs1[0 +: P], 7);
    chk("t1_rd0", phy_rd[0 +: P], 32);
    chk("t1_old0", phy_rd_old[0 +: P], 3);
    chk("t1_rs1_1", phy_rs1[P +: P], 32);
    chk("t1_rs2_1", phy_rs2[P +: P], 31);
    chk("t1_rd1", phy_rd[P +: P], 33);
    chk("t1_old1", phy_rd_old[P +: P], 32);
    step();
    clear_inputs();
    #1 chk("t1_fc_after", free_count, 30);

    // Exhaust the free list, then free two registers
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_lane(0, 1, 1, i, 0, (2*i) % 30 + 1);
      set_lane(1, 1, 1, 0, i, (2*i) % 30 + 2);
      step();
    end
    clear_inputs();
    #1;
    chk("t2_fc0", free_count, 0);
    chk("t2_ready0", rename_ready, 0);
`ifdef RMT_PERF_CNT_EN
    chk("perf_zero", rename_stall_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      rename_valid = 2'b11;
      step();
    end
    clear_inputs();
    #1 chk("perf_five", rename_stall_cnt, 5);
`endif
    clear_inputs(); set_commits(1); step();
    clear_inputs();
    #1;
    chk("t2_fc1", free_count, 1);
    chk("t2_ready1", rename_ready, 0);
    set_commits(1); step();
    clear_inputs();
    #1;
    chk("t2_fc2", free_count, 2);
    chk("t2_ready2", rename_ready, 1);
`ifdef RMT_PERF_CNT_EN
    flush = 1'b1; step();
    clear_inputs();
    #1 chk("perf_after_flush", rename_stall_cnt, 5);
    do_reset();
    #1 chk("perf_after_reset", rename_stall_cnt, 0);
`endif

    // Partial commit then flush restores precise state
    do_reset();
    set_lane(0, 1, 1, 0, 0, 5);
    set_lane(1, 1, 1, 0, 0, 6);
    step();
    clear_inputs(); set_commits(1); step();
    clear_inputs(); flush = 1'b1; step();
    clear_inputs();
    set_lane(0, 1, 1, 6, 5, 9);
    #1;
    chk("t3_x6", phy_rs1[0 +: P], 6);
    chk("t3_x5", phy_rs2[0 +: P], 32);
    chk("t3_fc", free_count, 32);
    chk("t3_next_alloc", phy_rd[0 +: P], 33);
    step();

    // rd = x0 never allocates
    do_reset();
    set_lane(0, 1, 1, 1, 2, 0);
    set_lane(1, 1, 1, 0, 0, 4);
    #1;
    chk("t4_rd0", phy_rd[0 +: P], 0);
    chk("t4_old0", phy_rd_old[0 +: P], 0);
    chk("t4_rd1", phy_rd[P +: P], 32);
    step();
    clear_inputs();
    #1 chk("t4_fc", free_count, 31);

    // Random traffic with commits and flushes; pointers wrap many times
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int k = 0; k < RW; k++)
        set_lane(k, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      set_commits($urandom_range(0, CW));
      flush = ($urandom_range(0, 24) == 0);
      step();
    end
    clear_inputs();
    flush = 1'b1;
    step();
    clear_inputs();
    #1 chk("final_fc", free_count, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
